// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared types and constants for the FND scan controller
package fnd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } conv_state_t;

  localparam int          NUM_DIGITS = 4;
  localparam int          DATA_W     = 14;
  localparam logic [13:0] OVF_LIMIT  = 14'd9999;

  // Active-low segments, dp (bit 7) off
  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_DASH  = 8'hBF;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  function automatic logic [7:0] digit_font(input logic [3:0] d);
    logic [7:0] f;
    case (d)
      4'd0:    f = FONT_0;
      4'd1:    f = FONT_1;
      4'd2:    f = FONT_2;
      4'd3:    f = FONT_3;
      4'd4:    f = FONT_4;
      4'd5:    f = FONT_5;
      4'd6:    f = FONT_6;
      4'd7:    f = FONT_7;
      4'd8:    f = FONT_8;
      4'd9:    f = FONT_9;
      default: f = FONT_BLANK;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/bin2bcd_14.sv
// rtl/bin2bcd_14.sv - 16-cycle double-dabble converter (IDLE capture, 14 SHIFT, LOAD)
module bin2bcd_14
  import fnd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] data,
  input  logic [3:0]  dot,
  output logic [15:0] bcd,
  output logic [3:0]  dots,
  output logic        ovf,
  output logic        load
);

  conv_state_t       state, state_next;
  logic [3:0]        shift_cnt;
  logic [DATA_W-1:0] sample;
  logic              capture, shift_en;
  logic [3:0]        n3, n2, n1, n0;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = SHIFT;
      SHIFT:   if (shift_cnt == 4'd13) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    capture  = 1'b0;
    shift_en = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE:    capture  = 1'b1;
      SHIFT:   shift_en = 1'b1;
      LOAD:    load     = 1'b1;
      default: ;
    endcase
  end

  assign n3 = add3(bcd[15:12]);
  assign n2 = add3(bcd[11:8]);
  assign n1 = add3(bcd[7:4]);
  assign n0 = add3(bcd[3:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample    <= '0;
      dots      <= '0;
      ovf       <= 1'b0;
      bcd       <= '0;
      shift_cnt <= '0;
    end else if (capture) begin
      sample    <= data;
      dots      <= dot;
      ovf       <= (data > OVF_LIMIT);
      bcd       <= '0;
      shift_cnt <= '0;
    end else if (shift_en) begin
      bcd       <= {n3[2:0], n2, n1, n0, sample[DATA_W-1]};
      sample    <= {sample[DATA_W-2:0], 1'b0};
      shift_cnt <= shift_cnt + 4'd1;
      // A carry out of the thousands nibble can only come from a value above the limit
      ovf       <= ovf | n3[3];
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - 4-digit 7-segment scan controller with binary-to-BCD front end
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] fndData,
  input  logic [3:0]  fndDot,
  output logic [3:0]  fndCom,
  output logic [7:0]  fndFont,
  output logic        bcdValid
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0]      pre_cnt;
  logic                  tick;
  logic [1:0]            idx, idx_next;
  logic [15:0]           conv_bcd, disp_bcd;
  logic [NUM_DIGITS-1:0] conv_dots, disp_dot;
  logic                  conv_ovf, conv_load, disp_ovf;
  logic [3:0]            nib, com_next;
  logic [7:0]            font_next;

  bin2bcd_14 u_conv (
    .clk   (clk),
    .reset (reset),
    .data  (fndData),
    .dot   (fndDot),
    .bcd   (conv_bcd),
    .dots  (conv_dots),
    .ovf   (conv_ovf),
    .load  (conv_load)
  );

  assign tick     = (pre_cnt == CNT_W'(SCAN_DIV - 1));
  assign idx_next = idx + 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      idx     <= 2'd0;
    end else if (tick) begin
      pre_cnt <= '0;
      idx     <= idx_next;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Display registers only change on LOAD, so the scan never sees a half-done conversion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_bcd <= '0;
      disp_dot <= '0;
      disp_ovf <= 1'b0;
      bcdValid <= 1'b0;
    end else begin
      bcdValid <= conv_load;
      if (conv_load) begin
        disp_bcd <= conv_bcd;
        disp_dot <= conv_dots;
        disp_ovf <= conv_ovf;
      end
    end
  end

  always_comb begin
    case (idx_next)
      2'd0:    nib = disp_bcd[3:0];
      2'd1:    nib = disp_bcd[7:4];
      2'd2:    nib = disp_bcd[11:8];
      default: nib = disp_bcd[15:12];
    endcase
    font_next = disp_ovf ? FONT_DASH : digit_font(nib);
    if (disp_dot[idx_next]) font_next[7] = 1'b0;
    com_next = ~(4'b0001 << idx_next);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fndCom  <= 4'b1111;
      fndFont <= FONT_BLANK;
    end else if (tick) begin
      fndCom  <= com_next;
      fndFont <= font_next;
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb/tb_fnd_scan_ctrl.sv - vector table, corner sequences and random run against a reference model
module tb_fnd_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] fndData;
  logic [3:0]  fndDot;
  logic [3:0]  fndCom;
  logic [7:0]  fndFont;
  logic        bcdValid;

  int total = 0;
  int bad   = 0;

  fnd_scan_ctrl #(.CLK_HZ(1000), .SCAN_HZ(100)) dut (
    .clk      (clk),
    .reset    (reset),
    .fndData  (fndData),
    .fndDot   (fndDot),
    .fndCom   (fndCom),
    .fndFont  (fndFont),
    .bcdValid (bcdValid)
  );

  always #5 clk = ~clk;

  logic [7:0] seg [10];
  initial begin
    seg[0] = 8'hC0; seg[1] = 8'hF9; seg[2] = 8'hA4; seg[3] = 8'hB0; seg[4] = 8'h99;
    seg[5] = 8'h92; seg[6] = 8'h82; seg[7] = 8'hF8; seg[8] = 8'h80; seg[9] = 8'h90;
  end

  function automatic logic [7:0] model_font(input int val, input logic [3:0] dots, input int d);
    logic [7:0] f;
    int p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    f = (val > 9999) ? 8'hBF : seg[(val / p) % 10];
    if (dots[d]) f[7] = 1'b0;
    return f;
  endfunction

  // Schedule model: edge n after release; capture on n%16==1, load on n%16==0, scan on n%10==0
  int         n;
  int         midx;
  int         cap_val, disp_val;
  logic [3:0] cap_dot, disp_dot;
  logic [3:0] exp_com;
  logic [7:0] exp_font;
  logic       exp_valid;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      n = 0; midx = 0; cap_val = 0; disp_val = 0; cap_dot = 0; disp_dot = 0;
      exp_com = 4'hF; exp_font = 8'hFF; exp_valid = 1'b0;
    end else begin
      n = n + 1;
      exp_valid = (n % 16 == 0);
      if (n % 10 == 0) begin
        midx     = (midx + 1) % 4;
        exp_com  = ~(4'b0001 << midx);
        exp_font = model_font(disp_val, disp_dot, midx);
      end
      if (n % 16 == 0) begin
        disp_val = cap_val;
        disp_dot = cap_dot;
      end
      if (n % 16 == 1) begin
        cap_val = int'(fndData);
        cap_dot = fndDot;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic check_en = 1'b0;
  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_com", {12'd0, fndCom}, {12'd0, exp_com});
      check("cyc_font", {8'd0, fndFont}, {8'd0, exp_font});
      check("cyc_valid", {15'd0, bcdValid}, {15'd0, exp_valid});
    end
  end

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bcdValid && cnt < 40);
    check("valid_seen", {15'd0, bcdValid}, 16'd1);
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(n > 0 && n % 10 == 0) && k < 20);
  endtask

  task automatic wait_phase(input int ph);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (n % 16 != ph && k < 40);
  endtask

  typedef struct packed {
    logic [13:0]      data;
    logic [3:0]       dot;
    logic [3:0][7:0]  f;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int cnt;
    int d;

    vecs[0] = {14'd1234,  4'b0000, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vecs[1] = {14'd0,     4'b0000, {8'hC0, 8'hC0, 8'hC0, 8'hC0}};
    vecs[2] = {14'd9999,  4'b0000, {8'h90, 8'h90, 8'h90, 8'h90}};
    vecs[3] = {14'd10000, 4'b0000, {8'hBF, 8'hBF, 8'hBF, 8'hBF}};
    vecs[4] = {14'd16383, 4'b0000, {8'hBF, 8'hBF, 8'hBF, 8'hBF}};
    vecs[5] = {14'd16383, 4'b1111, {8'h3F, 8'h3F, 8'h3F, 8'h3F}};
    vecs[6] = {14'd5678,  4'b0100, {8'h92, 8'h02, 8'hF8, 8'h80}};
    vecs[7] = {14'd9,     4'b1000, {8'h40, 8'hC0, 8'hC0, 8'h90}};

    reset = 1'b1;
    fndData = 14'd1234;
    fndDot = 4'b0000;
    repeat (3) @(negedge clk);
    check("reset_com", {12'd0, fndCom}, 16'h000F);
    check("reset_font", {8'd0, fndFont}, 16'h00FF);
    check("reset_valid", {15'd0, bcdValid}, 16'd0);
    check_en = 1'b1;
    reset = 1'b0;

    wait_valid(cnt);
    check("first_valid_latency", 16'(cnt), 16'd16);

    for (int i = 0; i < 8; i++) begin
      fndData = vecs[i].data;
      fndDot  = vecs[i].dot;
      wait_valid(cnt);
      wait_valid(cnt);
      for (int t = 0; t < 4; t++) begin
        wait_tick();
        case (fndCom)
          4'b1110: d = 0;
          4'b1101: d = 1;
          4'b1011: d = 2;
          4'b0111: d = 3;
          default: d = -1;
        endcase
        check("vec_com", {12'd0, fndCom}, {12'd0, exp_com});
        if (d >= 0) check($sformatf("vec%0d_digit%0d", i, d), {8'd0, fndFont}, {8'd0, vecs[i].f[d]});
      end
    end

    // Input change in the middle of SHIFT must not disturb the conversion in flight
    fndData = 14'd1111;
    fndDot  = 4'b0000;
    wait_phase(1);
    wait_phase(5);
    fndData = 14'd2222;
    wait_valid(cnt);
    wait_tick();
    check("midshift_old", {8'd0, fndFont}, 16'h00F9);
    wait_valid(cnt);
    wait_tick();
    check("midshift_new", {8'd0, fndFont}, 16'h00A4);

    // Reset during SHIFT cycle 7 blanks at once and restarts the conversion schedule
    wait_phase(7);
    #2 reset = 1'b1;
    #1;
    check("async_com", {12'd0, fndCom}, 16'h000F);
    check("async_font", {8'd0, fndFont}, 16'h00FF);
    check("async_valid", {15'd0, bcdValid}, 16'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_valid(cnt);
    check("valid_after_reset", 16'(cnt), 16'd16);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       fndData = 14'd9999;
          1:       fndData = 14'd10000;
          default: fndData = 14'($urandom_range(0, 16383));
        endcase
        fndDot = 4'($urandom_range(0, 15));
      end
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fnd_scan_ctrl.md
FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000, per-digit scan rate in Hz; SCAN_DIV = CLK_HZ/SCAN_HZ SHALL be an integer >= 2.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fndData  input  14  unsigned binary value to display, nominal range 0..9999.
REQ-006 fndDot  input  4  decimal-point request per digit, bit i = digit i, 1 = lit.
REQ-007 fndCom  output  4  digit enables, active-low, at most one bit low; bit 0 = ones digit.
REQ-008 fndFont  output  8  segments, active-low; [6:0] = g,f,e,d,c,b,a; [7] = dp.
REQ-009 bcdValid  output  1  one-cycle pulse when new display registers are loaded.

Function
REQ-010 A prescaler SHALL count 0..SCAN_DIV-1 and assert a one-cycle scan tick on the cycle it wraps.
REQ-011 A 2-bit digit index SHALL advance 0->1->2->3->0 on each scan tick.
REQ-012 fndCom/fndFont SHALL be registered and updated only on a scan tick, from the index value after that tick.
REQ-013 fndCom for index 0..3 SHALL be 4'b1110, 4'b1101, 4'b1011, 4'b0111.
REQ-014 Converter FSM states SHALL be IDLE, SHIFT and LOAD.
REQ-015 IDLE (1 cycle): capture fndData and fndDot into sample registers, then go to SHIFT unconditionally.
REQ-016 SHIFT (exactly 14 cycles): double-dabble; add 3 to each BCD nibble >= 5, then shift in the next sample bit, MSB first.
REQ-017 LOAD (1 cycle): copy the 4 BCD nibbles, the sampled dots and the overflow flag into display registers; pulse bcdValid; go to IDLE.
REQ-018 Conversion period SHALL be 16 cycles; fndData changes after capture SHALL NOT affect the conversion in progress.
REQ-019 Overflow: a sampled fndData > 9999 SHALL set the overflow flag; while it is set, all digits SHALL show dash 8'hBF, with the dp rule still applied.
REQ-020 Font encoding: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, dp off).
REQ-021 dp: if the display-register dot bit for the active digit is 1, fndFont[7] SHALL be 0.
REQ-022 No leading-zero suppression; 0 SHALL display as "0000".
REQ-023 The scan path SHALL read only display registers and SHALL never see partial conversion results.

Reset
REQ-024 On reset assertion, fndCom = 4'b1111 and fndFont = 8'hFF SHALL take effect asynchronously, without waiting for a clock edge.
REQ-025 Reset SHALL clear the prescaler, the digit index (0), the FSM (IDLE), the sample/BCD/display registers (value 0, dots 0, overflow 0) and bcdValid (0).
REQ-026 Reset mid-conversion SHALL abandon the conversion; the first bcdValid after release SHALL occur 16 cycles after the first active edge.
REQ-027 After release, outputs SHALL stay blank until the first scan tick.

Structure
REQ-028 Shared package fnd_pkg SHALL hold the FSM state enum, the segment font constants (digits 0-9, dash, blank), the overflow limit 9999 and the digit count 4.
REQ-029 Sub-module bin2bcd_14 SHALL contain the IDLE/SHIFT/LOAD converter; the top SHALL hold the prescaler, digit index, display registers and output mux.

Verification (CLK_HZ=1000, SCAN_HZ=100 -> tick every 10 cycles)
REQ-030 Run reset, then hold fndData=1234, fndDot=0 -> bcdValid 16 cycles after release; successive ticks give fndCom/fndFont 1110/99, 1101/B0, 1011/A4, 0111/F9, repeating.
REQ-031 Drive fndData=0, then 9999 -> all digits C0, then all digits 90.
REQ-032 Drive fndData=10000 and 16383 -> all four digits BF; fndDot=4'b1111 with overflow -> all digits 3F.
REQ-033 Drive fndData=5678, fndDot=4'b0100 -> digit0 80, digit1 F8, digit2 02, digit3 92.
REQ-034 Assert reset for 3 cycles at SHIFT cycle 7 -> fndCom=1111 and fndFont=FF immediately; no bcdValid until 16 cycles after release.
REQ-035 Change fndData 1111->2222 at SHIFT cycle 5 -> the next LOAD shows 1111; the following LOAD shows 2222.
